int_dispatch: RTL and testbench

//  Downstream of the interrupt priority encoder. Takes the registered 6-bit

---
 rtl/int_dispatch_if.sv | 22 ++
 rtl/int_dispatch.sv | 128 ++++++++++++
 tb/tb_int_dispatch.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_dispatch_if.sv
// Upstream encoder inputs and bridge req/ack handshake of the interrupt dispatcher.
interface int_dispatch_if #(
  parameter int unsigned CNT_W = 16
);
  logic [5:0]       sys_interrupt_source_i;
  logic             sys_int_enable_i;
  logic             int_req_o;
  logic [5:0]       int_src_o;
  logic             int_ack_i;
  logic             int_timeout_o;
  logic [CNT_W-1:0] int_sent_count_o;

  modport master (
    input  sys_interrupt_source_i, sys_int_enable_i, int_ack_i,
    output int_req_o, int_src_o, int_timeout_o, int_sent_count_o
  );

  modport slave (
    output sys_interrupt_source_i, sys_int_enable_i, int_ack_i,
    input  int_req_o, int_src_o, int_timeout_o, int_sent_count_o
  );
endinterface

// File: rtl/int_dispatch.sv
// Turns each new non-zero encoded interrupt source into one req/ack transaction
// to the packet bridge, with de-duplication, holdoff spacing, ack timeout and a sent counter.
module int_dispatch #(
  parameter int unsigned HOLDOFF     = 16,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic           sys_clock_i,
  input  logic           sys_reset_n_i,
  int_dispatch_if.master bus
);

  localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned HLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [5:0]       src_q, src_d;
  logic [5:0]       last_q, last_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [HLD_W-1:0] hld_q, hld_d;

  logic src_zero;
  logic src_new;

  assign src_zero = (bus.sys_interrupt_source_i == '0);
  assign src_new  = bus.sys_int_enable_i && !src_zero &&
                    (bus.sys_interrupt_source_i != last_q);

  always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      src_q   <= '0;
      last_q  <= '0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      hld_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      src_q   <= src_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      hld_q   <= hld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    src_d   = src_q;
    last_d  = last_q;
    tmo_d   = 1'b0;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    hld_d   = hld_q;

    unique case (state_q)
      IDLE: begin
        if (src_zero) begin
          last_d = '0;
        end else if (src_new) begin
          src_d   = bus.sys_interrupt_source_i;
          req_d   = 1'b1;
          tmr_d   = '0;
          state_d = REQ;
        end
      end

      // Ack takes priority over timeout expiry on the same cycle; an abandoned
      // source is still recorded so it is not re-sent while held.
      REQ: begin
        if (bus.int_ack_i) begin
          req_d   = 1'b0;
          last_d  = src_q;
          hld_d   = '0;
          state_d = HOLD;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmr_q == TMR_LAST) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          last_d  = src_q;
          hld_d   = '0;
          state_d = HOLD;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      HOLD: begin
        if (src_zero) begin
          last_d = '0;
        end
        if (hld_q == HLD_LAST) begin
          state_d = IDLE;
        end else begin
          hld_d = hld_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.int_req_o        = req_q;
  assign bus.int_src_o        = src_q;
  assign bus.int_timeout_o    = tmo_q;
  assign bus.int_sent_count_o = cnt_q;

endmodule

// File: tb/tb_int_dispatch.sv
// Directed bench for int_dispatch: main instance with default parameters and a
// second instance with a 2-bit counter, no holdoff and a short ack timeout.
module tb_int_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  int_dispatch_if #(.CNT_W(16)) bus ();
  int_dispatch_if #(.CNT_W(2))  sbus ();

  int_dispatch #(
    .HOLDOFF(16),
    .ACK_TIMEOUT(255),
    .CNT_W(16)
  ) dut (
    .sys_clock_i(clk),
    .sys_reset_n_i(rst_n),
    .bus(bus)
  );

  int_dispatch #(
    .HOLDOFF(0),
    .ACK_TIMEOUT(4),
    .CNT_W(2)
  ) dut_sat (
    .sys_clock_i(clk),
    .sys_reset_n_i(rst_n),
    .bus(sbus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    bus.int_ack_i = 1'b1;
    tick();
    bus.int_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned n;
    bus.sys_interrupt_source_i  = 6'd0;
    bus.sys_int_enable_i        = 1'b0;
    bus.int_ack_i               = 1'b0;
    sbus.sys_interrupt_source_i = 6'd0;
    sbus.sys_int_enable_i       = 1'b0;
    sbus.int_ack_i              = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.int_req_o !== 1'b0) begin
      errors++; $display("FAIL reset_req got %0b expected 0", bus.int_req_o);
    end
    checks++;
    if (bus.int_src_o !== 6'd0) begin
      errors++; $display("FAIL reset_src got %0d expected 0", bus.int_src_o);
    end
    checks++;
    if (bus.int_timeout_o !== 1'b0) begin
      errors++; $display("FAIL reset_timeout got %0b expected 0", bus.int_timeout_o);
    end
    checks++;
    if (bus.int_sent_count_o !== 16'd0) begin
      errors++; $display("FAIL reset_count got %0d expected 0", bus.int_sent_count_o);
    end
    rst_n = 1'b1;
    bus.sys_int_enable_i = 1'b1;
    n = 0;
    repeat (100) begin
      tick();
      if (bus.int_req_o !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL idle_no_req got %0d req cycles expected 0", n);
    end
  endtask

  task automatic test_single_dispatch();
    int unsigned n;
    bus.sys_interrupt_source_i = 6'd5;
    tick();
    checks++;
    if (bus.int_req_o !== 1'b1 || bus.int_src_o !== 6'd5) begin
      errors++; $display("FAIL first_req got req=%0b src=%0d expected req=1 src=5",
                         bus.int_req_o, bus.int_src_o);
    end
    tick();
    tick();
    checks++;
    if (bus.int_req_o !== 1'b1) begin
      errors++; $display("FAIL req_held got %0b expected 1", bus.int_req_o);
    end
    pulse_ack();
    checks++;
    if (bus.int_req_o !== 1'b0 || bus.int_sent_count_o !== 16'd1) begin
      errors++; $display("FAIL first_ack got req=%0b count=%0d expected req=0 count=1",
                         bus.int_req_o, bus.int_sent_count_o);
    end
    // stray ack while holding must not count
    pulse_ack();
    n = 0;
    repeat (200) begin
      tick();
      if (bus.int_req_o !== 1'b0) n++;
    end
    checks++;
    if (n != 0 || bus.int_sent_count_o !== 16'd1) begin
      errors++; $display("FAIL dedup got %0d req cycles count=%0d expected 0 and 1",
                         n, bus.int_sent_count_o);
    end
  endtask

  task automatic test_rearm();
    int unsigned n;
    bus.sys_interrupt_source_i = 6'd0;
    tick();
    bus.sys_interrupt_source_i = 6'd5;
    tick();
    checks++;
    if (bus.int_req_o !== 1'b1 || bus.int_src_o !== 6'd5) begin
      errors++; $display("FAIL rearm_req got req=%0b src=%0d expected req=1 src=5",
                         bus.int_req_o, bus.int_src_o);
    end
    pulse_ack();
    checks++;
    if (bus.int_sent_count_o !== 16'd2) begin
      errors++; $display("FAIL rearm_count got %0d expected 2", bus.int_sent_count_o);
    end
    bus.sys_interrupt_source_i = 6'd9;
    n = 0;
    repeat (16) begin
      tick();
      if (bus.int_req_o !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL holdoff_quiet got %0d req cycles expected 0", n);
    end
    tick();
    checks++;
    if (bus.int_req_o !== 1'b1 || bus.int_src_o !== 6'd9) begin
      errors++; $display("FAIL new_src_req got req=%0b src=%0d expected req=1 src=9",
                         bus.int_req_o, bus.int_src_o);
    end
    pulse_ack();
    checks++;
    if (bus.int_sent_count_o !== 16'd3) begin
      errors++; $display("FAIL new_src_count got %0d expected 3", bus.int_sent_count_o);
    end
  endtask

  task automatic test_timeout();
    int unsigned n;
    bus.sys_interrupt_source_i = 6'd0;
    repeat (20) tick();
    bus.sys_interrupt_source_i = 6'd20;
    tick();
    n = 0;
    for (int i = 0; i < 400 && bus.int_req_o === 1'b1; i++) begin
      n++;
      tick();
    end
    checks++;
    if (n != 255) begin
      errors++; $display("FAIL timeout_len got %0d req cycles expected 255", n);
    end
    checks++;
    if (bus.int_timeout_o !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse got %0b expected 1", bus.int_timeout_o);
    end
    tick();
    checks++;
    if (bus.int_timeout_o !== 1'b0 || bus.int_sent_count_o !== 16'd3) begin
      errors++; $display("FAIL timeout_after got pulse=%0b count=%0d expected 0 and 3",
                         bus.int_timeout_o, bus.int_sent_count_o);
    end
    bus.sys_interrupt_source_i = 6'd21;
    for (int i = 0; i < 40 && bus.int_req_o !== 1'b1; i++) tick();
    checks++;
    if (bus.int_req_o !== 1'b1 || bus.int_src_o !== 6'd21) begin
      errors++; $display("FAIL late_req got req=%0b src=%0d expected req=1 src=21",
                         bus.int_req_o, bus.int_src_o);
    end
    n = 0;
    repeat (254) begin
      tick();
      if (bus.int_req_o !== 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL late_held got %0d low cycles expected 0", n);
    end
    // ack coincides with the cycle the timeout would fire
    pulse_ack();
    checks++;
    if (bus.int_req_o !== 1'b0 || bus.int_timeout_o !== 1'b0 ||
        bus.int_sent_count_o !== 16'd4) begin
      errors++; $display("FAIL late_ack got req=%0b pulse=%0b count=%0d expected 0 0 4",
                         bus.int_req_o, bus.int_timeout_o, bus.int_sent_count_o);
    end
  endtask

  task automatic test_req_freeze();
    int unsigned n;
    bus.sys_interrupt_source_i = 6'd5;
    for (int i = 0; i < 40 && bus.int_req_o !== 1'b1; i++) tick();
    checks++;
    if (bus.int_req_o !== 1'b1 || bus.int_src_o !== 6'd5) begin
      errors++; $display("FAIL freeze_req got req=%0b src=%0d expected req=1 src=5",
                         bus.int_req_o, bus.int_src_o);
    end
    bus.sys_interrupt_source_i = 6'd12;
    bus.sys_int_enable_i       = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.int_req_o !== 1'b1 || bus.int_src_o !== 6'd5) begin
      errors++; $display("FAIL freeze_hold got req=%0b src=%0d expected req=1 src=5",
                         bus.int_req_o, bus.int_src_o);
    end
    pulse_ack();
    checks++;
    if (bus.int_req_o !== 1'b0 || bus.int_src_o !== 6'd5 ||
        bus.int_sent_count_o !== 16'd5) begin
      errors++; $display("FAIL freeze_ack got req=%0b src=%0d count=%0d expected 0 5 5",
                         bus.int_req_o, bus.int_src_o, bus.int_sent_count_o);
    end
    n = 0;
    repeat (40) begin
      tick();
      if (bus.int_req_o !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL disabled_quiet got %0d req cycles expected 0", n);
    end
    bus.sys_int_enable_i = 1'b1;
    tick();
    checks++;
    if (bus.int_req_o !== 1'b1 || bus.int_src_o !== 6'd12) begin
      errors++; $display("FAIL enable_req got req=%0b src=%0d expected req=1 src=12",
                         bus.int_req_o, bus.int_src_o);
    end
    pulse_ack();
    checks++;
    if (bus.int_sent_count_o !== 16'd6) begin
      errors++; $display("FAIL enable_count got %0d expected 6", bus.int_sent_count_o);
    end
  endtask

  task automatic test_reset_mid_req();
    bus.sys_interrupt_source_i = 6'd7;
    for (int i = 0; i < 40 && bus.int_req_o !== 1'b1; i++) tick();
    checks++;
    if (bus.int_req_o !== 1'b1) begin
      errors++; $display("FAIL midreq_req got %0b expected 1", bus.int_req_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.int_req_o !== 1'b0 || bus.int_src_o !== 6'd0 ||
        bus.int_sent_count_o !== 16'd0) begin
      errors++; $display("FAIL async_reset got req=%0b src=%0d count=%0d expected 0 0 0",
                         bus.int_req_o, bus.int_src_o, bus.int_sent_count_o);
    end
    bus.sys_interrupt_source_i = 6'd0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.int_req_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_req got %0b expected 0", bus.int_req_o);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    sbus.sys_int_enable_i = 1'b1;
    for (int unsigned i = 1; i <= 5; i++) begin
      sbus.sys_interrupt_source_i = (i % 2 == 1) ? 6'd1 : 6'd2;
      for (int k = 0; k < 10 && sbus.int_req_o !== 1'b1; k++) tick();
      checks++;
      if (sbus.int_req_o !== 1'b1) begin
        errors++; $display("FAIL sat_req_%0d got %0b expected 1", i, sbus.int_req_o);
      end
      sbus.int_ack_i = 1'b1;
      tick();
      sbus.int_ack_i = 1'b0;
      exp_cnt = (i > 3) ? 2'd3 : 2'(i);
      checks++;
      if (sbus.int_sent_count_o !== exp_cnt) begin
        errors++; $display("FAIL sat_count_%0d got %0d expected %0d",
                           i, sbus.int_sent_count_o, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_dispatch();
    test_rearm();
    test_timeout();
    test_req_freeze();
    test_reset_mid_req();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
